// File: rtl/scroll_pacer.sv
// scroll_pacer: paces the banner scroller on the six-digit 7-segment display.
//   A debounced, active-low run button starts/pauses scrolling. While running,
//   a divider emits a one-cycle `step` every (BASE_DIV >> speed) cycles and
//   advances the banner position `pos`. Continuous mode loops forever; single
//   mode stops in IDLE after one full rotation.
// Ports:
//   clock      system clock (rising edge)
//   reset      synchronous, active-high
//   run_btn    raw pushbutton, active-low, asynchronous
//   speed[1:0] rate select: period = BASE_DIV >> speed
//   mode       0 = continuous, 1 = single pass
//   step       one-cycle shift enable to the scroller
//   pos[3:0]   current banner position, 0..NUM_POS-1
//   running    high while in RUN
//   pass_done  one-cycle pulse coincident with the step that wraps pos
module scroll_pacer #(
  parameter int BASE_DIV     = 12_500_000,
  parameter int NUM_POS      = 14,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_btn,
  input  logic [1:0] speed,
  input  logic       mode,
  output logic       step,
  output logic [3:0] pos,
  output logic       running,
  output logic       pass_done
);

  localparam int DIV_W = ($clog2(BASE_DIV + 1) > 24) ? $clog2(BASE_DIV + 1) : 24;
  localparam int DB_W  = ($clog2(DEBOUNCE_CYC + 1) > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  localparam logic [DIV_W-1:0] BASE     = DIV_W'(BASE_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [3:0]       POS_LAST = 4'(NUM_POS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // ---------------- button path ----------------
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            deb_q, deb_d;
  logic            deb_prev_q, deb_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;

  always_comb begin
    sync1_d    = run_btn;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    // Count consecutive cycles the synced level disagrees with the accepted
    // level; any agreeing cycle drops the count back to zero.
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) deb_d    = sync2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
    deb_prev_d = deb_q;
    // Registered falling-edge detect: press is one cycle, release is ignored.
    press_d    = deb_prev_q & ~deb_q;
  end

  // ---------------- control path ----------------
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [3:0]       pos_q, pos_d;
  logic             step_q, step_d;
  logic             pass_done_q, pass_done_d;
  logic             running_q, running_d;
  logic [DIV_W-1:0] per_new;
  logic             at_end;
  logic             wrap;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    per_d       = per_q;
    pos_d       = pos_q;
    step_d      = 1'b0;
    pass_done_d = 1'b0;
    per_new     = BASE >> speed;
    at_end      = (div_q == per_q - DIV_W'(1));
    wrap        = (pos_q == POS_LAST);
    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          state_d = S_RUN;
          pos_d   = '0;
          div_d   = '0;
          per_d   = per_new;
        end
      end
      S_RUN: begin
        if (at_end) begin
          // The step always goes out; a coincident press only pauses after
          // it, and a final single-pass wrap swallows the press.
          step_d      = 1'b1;
          pass_done_d = wrap;
          pos_d       = wrap ? 4'd0 : pos_q + 4'd1;
          div_d       = '0;
          per_d       = per_new;
          if (wrap && mode) state_d = S_IDLE;
          else if (press_q) state_d = S_PAUSE;
        end else if (press_q) begin
          // Divider holds so the resumed period is only the remainder.
          state_d = S_PAUSE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_PAUSE: begin
        if (press_q) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      deb_q       <= 1'b1;
      deb_prev_q  <= 1'b1;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      state_q     <= S_IDLE;
      div_q       <= '0;
      per_q       <= BASE;
      pos_q       <= '0;
      step_q      <= 1'b0;
      pass_done_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_prev_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      div_q       <= div_d;
      per_q       <= per_d;
      pos_q       <= pos_d;
      step_q      <= step_d;
      pass_done_q <= pass_done_d;
      running_q   <= running_d;
    end
  end

  assign step      = step_q;
  assign pos       = pos_q;
  assign running   = running_q;
  assign pass_done = pass_done_q;

endmodule
